hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have clk  in  1  single rising-edge clock.
REQ-002 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have rs_ID, rt_ID  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have useRs_ID, useRt_ID  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have rw_ID  in  5  destination register of the ID instruction.
REQ-006 SHALL have RegWr_ID, MemtoReg_ID  in  1 each  ID instruction writes the register file / is a load.
REQ-007 SHALL have flush_ID  in  1  taken branch/jump; the ID instruction is killed this cycle.
REQ-008 SHALL have freeze  in  1  global pipeline hold (memory wait); all state holds.
REQ-009 SHALL have BusAFw, BusBFw  out  2 each  registered EX-stage forward selects: 00 busA/busB_EX, 01 Di (WB data), 10 ALUout_M, 11 never driven.
REQ-010 SHALL have stall_ID  out  1  hold PC and IF/ID this cycle.
REQ-011 SHALL have bubble_EX  out  1  load a NOP into ID/EX at this edge.

Function
REQ-012 SHALL keep shadow destination records for EX and MEM stages: {rw, RegWr, MemtoReg}, advanced each non-frozen edge (ID->EX, EX->MEM).
REQ-013 SHALL compute forward selects in ID and register them at the edge the instruction enters EX, so they are valid throughout its EX cycle.
REQ-014 SHALL select 10 for an operand when the shadow-EX record (becoming MEM) has RegWr=1, MemtoReg=0, rw!=0, rw equals the source, and the source is used.
REQ-015 SHALL select 01 when REQ-014 does not match and the shadow-MEM record (becoming WB) has RegWr=1, rw!=0, rw equals the source, and the source is used.
REQ-016 SHALL give 10 priority over 01 when both stages match (newest value wins).
REQ-017 SHALL select 00 otherwise, including distance-3 producers (register file writes before it reads) and register 0.
REQ-018 SHALL detect load-use when the shadow-EX record has MemtoReg=1, RegWr=1, rw!=0, and rw matches a used rs_ID/rt_ID.
REQ-019 SHALL implement FSM RUN/STALL: RUN + load-use + !flush_ID + !freeze -> STALL with stall_ID=1, bubble_EX=1 that cycle; STALL -> RUN unconditionally next non-frozen edge; stall is exactly one cycle per load.
REQ-020 SHALL, on a bubble edge, write {rw=0, RegWr=0, MemtoReg=0} into shadow EX and register selects 00.
REQ-021 SHALL make the re-presented consumer after a stall see the load in MEM-to-WB and select 01 (Di).
REQ-022 SHALL give flush_ID priority over load-use: stall_ID=0, bubble_EX=1, shadow EX cleared, FSM stays RUN.
REQ-023 SHALL, while freeze=1, hold shadows, FSM state and BusAFw/BusBFw, and drive stall_ID=0 and bubble_EX=0.
REQ-024 SHALL derive stall_ID and bubble_EX combinationally from the current state and inputs.

Reset
REQ-025 SHALL, on rst_n=0 at an edge, clear both shadow records, set FSM to RUN, and set BusAFw=BusBFw=00; stall_ID=bubble_EX=0 while rst_n=0.
REQ-026 SHALL give reset priority over freeze and flush_ID, and abort a STALL in progress.

Structure
REQ-027 SHALL place the select encodings (FW_REG=00, FW_WB=01, FW_MEM=10), the FSM state encoding, and the register-number width in a shared package, for reuse by the EX forwarding muxes.
REQ-028 SHALL instantiate one sub-module, fwd_sel, used twice (rs and rt), that maps {source, use, EX record, MEM record} to a 2-bit select.

Verification
REQ-029 SHALL verify add r3 then add r4,r3,r3 back-to-back -> BusAFw=BusBFw=10 in the consumer's EX cycle, no stall.
REQ-030 SHALL verify producer r5, independent instruction, then consumer rt=r5 -> BusBFw=01, BusAFw=00.
REQ-031 SHALL verify lw r7 then add r8,r7,r1 -> one cycle stall_ID=1, bubble_EX=1, then BusAFw=01 for add, no second stall.
REQ-032 SHALL verify lw r7 followed by a use of r7 with flush_ID=1 in the same cycle -> stall_ID=0, bubble_EX=1, next EX selects 00.
REQ-033 SHALL verify writes to r0 at distance 1 and 2 -> selects stay 00; both stages writing r9 -> 10.
REQ-034 SHALL verify rst_n=0 asserted during STALL and held with freeze=1 -> next edge outputs 00/0/0, FSM RUN, shadows cleared.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// rtl/hazard_fwd_unit_pkg.sv - shared encodings and records for hazard detection and EX forwarding
package hazard_fwd_unit_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FW_REG = 2'b00,
        FW_WB  = 2'b01,
        FW_MEM = 2'b10
    } fw_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic [REG_W-1:0] rw;
        logic             reg_wr;
        logic             mem_to_reg;
    } dst_rec_t;

    localparam dst_rec_t DST_NONE = '0;

    // True when a record will write a live (non-r0) register that a used source reads.
    function automatic logic writes_src(input dst_rec_t rec, input logic [REG_W-1:0] src,
                                        input logic use_src);
        return use_src && rec.reg_wr && (rec.rw != '0) && (rec.rw == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forward select from the EX and MEM destination records
module fwd_sel
    import hazard_fwd_unit_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  dst_rec_t         ex_rec,
    input  dst_rec_t         mem_rec,
    output fw_sel_e          sel
);

    // A load in EX has no data yet; load-use stalling covers that case.
    always_comb begin
        sel = FW_REG;
        if (writes_src(ex_rec, src, use_src) && !ex_rec.mem_to_reg) begin
            sel = FW_MEM;
        end else if (writes_src(mem_rec, src, use_src)) begin
            sel = FW_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use stall FSM, shadow destination records, registered forward selects
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             useRs_ID,
    input  logic             useRt_ID,
    input  logic [REG_W-1:0] rw_ID,
    input  logic             RegWr_ID,
    input  logic             MemtoReg_ID,
    input  logic             flush_ID,
    input  logic             freeze,
    output logic [1:0]       BusAFw,
    output logic [1:0]       BusBFw,
    output logic             stall_ID,
    output logic             bubble_EX
);

    dst_rec_t   sh_ex;
    dst_rec_t   sh_mem;
    fsm_state_e state;
    fsm_state_e state_nxt;
    fw_sel_e    sel_a;
    fw_sel_e    sel_b;
    logic       load_use;

    fwd_sel u_sel_rs (
        .src     (rs_ID),
        .use_src (useRs_ID),
        .ex_rec  (sh_ex),
        .mem_rec (sh_mem),
        .sel     (sel_a)
    );

    fwd_sel u_sel_rt (
        .src     (rt_ID),
        .use_src (useRt_ID),
        .ex_rec  (sh_ex),
        .mem_rec (sh_mem),
        .sel     (sel_b)
    );

    assign load_use = sh_ex.mem_to_reg &&
                      (writes_src(sh_ex, rs_ID, useRs_ID) || writes_src(sh_ex, rt_ID, useRt_ID));

    always_comb begin
        state_nxt = state;
        stall_ID  = 1'b0;
        bubble_EX = 1'b0;
        if (rst_n && !freeze) begin
            case (state)
                ST_RUN: begin
                    // A killed instruction cannot consume the load, so flush wins.
                    if (flush_ID) begin
                        bubble_EX = 1'b1;
                    end else if (load_use) begin
                        stall_ID  = 1'b1;
                        bubble_EX = 1'b1;
                        state_nxt = ST_STALL;
                    end
                end
                ST_STALL: begin
                    bubble_EX = flush_ID;
                    state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            sh_ex  <= DST_NONE;
            sh_mem <= DST_NONE;
            BusAFw <= FW_REG;
            BusBFw <= FW_REG;
        end else if (!freeze) begin
            state  <= state_nxt;
            sh_mem <= sh_ex;
            if (bubble_EX) begin
                sh_ex  <= DST_NONE;
                BusAFw <= FW_REG;
                BusBFw <= FW_REG;
            end else begin
                sh_ex  <= '{rw: rw_ID, reg_wr: RegWr_ID, mem_to_reg: MemtoReg_ID};
                BusAFw <= sel_a;
                BusBFw <= sel_b;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed vector table plus randomized run against a pipeline-history model
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_ID = '0, rt_ID = '0, rw_ID = '0;
    logic       useRs_ID = 1'b0, useRt_ID = 1'b0, RegWr_ID = 1'b0, MemtoReg_ID = 1'b0;
    logic       flush_ID = 1'b0, freeze = 1'b0;
    logic [1:0] BusAFw, BusBFw;
    logic       stall_ID, bubble_EX;

    int checks = 0;
    int failures = 0;

    hazard_fwd_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_ID       (rs_ID),
        .rt_ID       (rt_ID),
        .useRs_ID    (useRs_ID),
        .useRt_ID    (useRt_ID),
        .rw_ID       (rw_ID),
        .RegWr_ID    (RegWr_ID),
        .MemtoReg_ID (MemtoReg_ID),
        .flush_ID    (flush_ID),
        .freeze      (freeze),
        .BusAFw      (BusAFw),
        .BusBFw      (BusBFw),
        .stall_ID    (stall_ID),
        .bubble_EX   (bubble_EX)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rstn, frz, fl;
        int rs, rt;
        bit ur, ut;
        int rw;
        bit wr, ld;
        bit e_st, e_bb;
        int e_a, e_b;
    } vec_t;

    typedef struct {
        int rw;
        bit wr, ld;
    } instr_t;

    vec_t   tbl[$];
    instr_t hist[$];
    int     m_a, m_b;
    bit     m_stalled;

    function automatic vec_t mk(bit rstn, bit frz, bit fl, int rs, int rt, bit ur, bit ut,
                                int rw, bit wr, bit ld, bit e_st, bit e_bb, int e_a, int e_b);
        vec_t v;
        v.rstn = rstn; v.frz = frz; v.fl = fl; v.rs = rs; v.rt = rt; v.ur = ur; v.ut = ut;
        v.rw = rw; v.wr = wr; v.ld = ld; v.e_st = e_st; v.e_bb = e_bb; v.e_a = e_a; v.e_b = e_b;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rstn; freeze = v.frz; flush_ID = v.fl;
        rs_ID = 5'(v.rs); rt_ID = 5'(v.rt); useRs_ID = v.ur; useRt_ID = v.ut;
        rw_ID = 5'(v.rw); RegWr_ID = v.wr; MemtoReg_ID = v.ld;
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] act, input int exp);
        checks++;
        if (act !== 2'(exp)) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Youngest producer wins; distance 1 = instruction now leaving EX, distance 2 = leaving MEM.
    function automatic int model_sel(int src, bit used);
        for (int d = 0; d < 2; d++) begin
            if (d < hist.size() && used && src != 0 && hist[d].wr && hist[d].rw == src) begin
                if (d == 0 && hist[d].ld) continue;
                return (d == 0) ? 2 : 1;
            end
        end
        return 0;
    endfunction

    function automatic bit model_load_use(vec_t v);
        if (hist.size() == 0) return 1'b0;
        if (!(hist[0].ld && hist[0].wr && hist[0].rw != 0)) return 1'b0;
        return (v.ur && v.rs == hist[0].rw) || (v.ut && v.rt == hist[0].rw);
    endfunction

    initial begin
        // reset
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
        // add r3; add r4,r3,r3; nop
        tbl.push_back(mk(1,0,0, 1,2,1,1, 3,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 3,3,1,1, 4,1,0, 0,0,2,2));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
        // add r5; add r6; consumer rt=r5; nop
        tbl.push_back(mk(1,0,0, 1,2,1,1, 5,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 1,2,1,1, 6,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 1,5,1,1, 10,1,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
        // lw r7; add r8,r7,r1 (stall, re-presented); nop
        tbl.push_back(mk(1,0,0, 1,0,1,0, 7,1,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 7,1,1,1, 8,1,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0, 7,1,1,1, 8,1,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
        // lw r7; use of r7 flushed; independent
        tbl.push_back(mk(1,0,0, 1,0,1,0, 7,1,1, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 7,1,1,1, 8,1,0, 0,1,0,0));
        tbl.push_back(mk(1,0,0, 1,2,1,1, 11,1,0, 0,0,0,0));
        // r0 writers at distance 1 and 2
        tbl.push_back(mk(1,0,0, 1,2,1,1, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,1,1, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,1,1, 12,1,0, 0,0,0,0));
        // r9 in both stages, then distance 2 and 3
        tbl.push_back(mk(1,0,0, 1,2,1,1, 9,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 1,2,1,1, 9,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 9,9,1,1, 13,1,0, 0,0,2,2));
        tbl.push_back(mk(1,0,0, 9,1,1,1, 14,1,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0, 9,9,1,1, 15,1,0, 0,0,0,0));
        // lw r7; frozen consumer; stall; reset during STALL with freeze+flush
        tbl.push_back(mk(1,0,0, 1,0,1,0, 7,1,1, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 7,1,1,1, 8,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 7,1,1,1, 8,1,0, 1,1,0,0));
        tbl.push_back(mk(0,1,1, 7,7,1,1, 8,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 7,7,1,1, 16,1,0, 0,0,0,0));
        // load-use after reset, then freeze holding a non-zero select
        tbl.push_back(mk(1,0,0, 1,0,1,0, 7,1,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 7,1,1,1, 8,1,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0, 7,1,1,1, 8,1,0, 0,0,1,0));
        tbl.push_back(mk(1,1,0, 8,8,1,1, 17,1,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0, 8,8,1,1, 17,1,0, 0,0,2,2));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check("dir_stall", i, {1'b0, stall_ID}, int'(tbl[i].e_st));
            check("dir_bubble", i, {1'b0, bubble_EX}, int'(tbl[i].e_bb));
            @(posedge clk);
            #1;
            check("dir_busa", i, BusAFw, tbl[i].e_a);
            check("dir_busb", i, BusBFw, tbl[i].e_b);
        end

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            bit   e_st, e_bb, lu;
            int   na, nb;
            instr_t rec;
            v.rstn = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            v.frz  = ($urandom_range(0, 5) == 0);
            v.fl   = ($urandom_range(0, 7) == 0);
            v.rs   = $urandom_range(0, 3);
            v.rt   = $urandom_range(0, 3);
            v.ur   = $urandom_range(0, 3) != 0;
            v.ut   = $urandom_range(0, 3) != 0;
            v.rw   = $urandom_range(0, 3);
            v.wr   = $urandom_range(0, 3) != 0;
            v.ld   = $urandom_range(0, 2) == 0;
            @(negedge clk);
            drive(v);
            lu = model_load_use(v);
            e_st = v.rstn && !v.frz && !v.fl && !m_stalled && lu;
            e_bb = v.rstn && !v.frz && (v.fl || e_st);
            #1;
            check("rnd_stall", i, {1'b0, stall_ID}, int'(e_st));
            check("rnd_bubble", i, {1'b0, bubble_EX}, int'(e_bb));
            if (!v.rstn) begin
                hist.delete();
                m_a = 0; m_b = 0; m_stalled = 1'b0;
            end else if (!v.frz) begin
                na = e_bb ? 0 : model_sel(v.rs, v.ur);
                nb = e_bb ? 0 : model_sel(v.rt, v.ut);
                rec.rw = e_bb ? 0 : v.rw;
                rec.wr = e_bb ? 1'b0 : v.wr;
                rec.ld = e_bb ? 1'b0 : v.ld;
                hist.push_front(rec);
                if (hist.size() > 2) void'(hist.pop_back());
                m_a = na; m_b = nb; m_stalled = e_st;
            end
            @(posedge clk);
            #1;
            check("rnd_busa", i, BusAFw, m_a);
            check("rnd_busb", i, BusBFw, m_b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
